sap1_program_loader: RTL and testbench

- Write-side counterpart to the SAP-1 read path: streams a program image into the 16x8 SAP-1 memory through its write port, then reads it back to verify it.
- Holds the CPU in reset while loading and releases it only after a verified load.
- Sits between a byte source (host/bench) and the memory's write/read port, multiplexed ahead of the MAR address path.
- Replaces the tied-off mem_write (1'b0) / data_in (8'b0) connection at the top level.

---
 rtl/sap1_program_loader_if.sv | 25 ++
 rtl/sap1_program_loader.sv | 157 +++++++++++++++
 tb/tb_sap1_program_loader.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/sap1_program_loader_if.sv
// Byte-source and memory-port signals shared by the SAP-1 program loader.
// The master side is the loader itself; the slave side is the source/memory.
interface sap1_program_loader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  in_valid, in_data, mem_rdata,
        output in_ready, mem_addr, mem_wdata, mem_write, mem_read
    );

    modport slave (
        output in_valid, in_data, mem_rdata,
        input  in_ready, mem_addr, mem_wdata, mem_write, mem_read
    );
endinterface

// File: rtl/sap1_program_loader.sv
// Streams a program image into the SAP-1 memory, reads it back to verify the
// checksum, and holds the CPU in reset until a verified load has completed.
module sap1_program_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    sap1_program_loader_if.master bus,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  load_error,
    output logic [DATA_W-1:0]     checksum
);
    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_LOAD        = 3'd1;
    localparam logic [2:0] S_VERIFY_REQ  = 3'd2;
    localparam logic [2:0] S_VERIFY_WAIT = 3'd3;
    localparam logic [2:0] S_DONE        = 3'd4;
    localparam logic [2:0] S_ERROR       = 3'd5;

    localparam int                WAIT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [DATA_W-1:0] checksum_q, checksum_d;
    logic [DATA_W-1:0] rsum_q, rsum_d;
    logic              in_ready_q, in_ready_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_write_q, mem_write_d;
    logic              mem_read_q, mem_read_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              load_done_q, load_done_d;
    logic              load_error_q, load_error_d;

    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wait_d      = wait_q;
        checksum_d  = checksum_q;
        rsum_d      = rsum_q;
        in_ready_d  = in_ready_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_write_d = 1'b0;
        mem_read_d  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d    = S_LOAD;
                    cnt_d      = '0;
                    checksum_d = '0;
                    rsum_d     = '0;
                    in_ready_d = 1'b1;
                end
            end
            S_LOAD: begin
                // in_ready low here means the final write is on the bus this cycle.
                if (!in_ready_q) begin
                    state_d    = S_VERIFY_REQ;
                    cnt_d      = '0;
                    mem_read_d = 1'b1;
                    mem_addr_d = '0;
                end else if (bus.in_valid) begin
                    mem_write_d = 1'b1;
                    mem_addr_d  = cnt_q;
                    mem_wdata_d = bus.in_data;
                    checksum_d  = checksum_q + bus.in_data;
                    cnt_d       = cnt_q + 1'b1;
                    if (cnt_q == LAST_ADDR) begin
                        in_ready_d = 1'b0;
                    end
                end
            end
            S_VERIFY_REQ: begin
                state_d = S_VERIFY_WAIT;
                wait_d  = '0;
            end
            S_VERIFY_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    rsum_d = rsum_q + bus.mem_rdata;
                    if (cnt_q == LAST_ADDR) begin
                        state_d = (rsum_d == checksum_q) ? S_DONE : S_ERROR;
                    end else begin
                        // Strobe the next read as the state re-enters VERIFY_REQ.
                        state_d    = S_VERIFY_REQ;
                        cnt_d      = cnt_q + 1'b1;
                        mem_read_d = 1'b1;
                        mem_addr_d = cnt_q + 1'b1;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cpu_reset_d  = (state_d != S_DONE);
        load_done_d  = (state_d == S_DONE);
        load_error_d = (state_d == S_ERROR);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            wait_q       <= '0;
            checksum_q   <= '0;
            rsum_q       <= '0;
            in_ready_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            cpu_reset_q  <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wait_q       <= wait_d;
            checksum_q   <= checksum_d;
            rsum_q       <= rsum_d;
            in_ready_q   <= in_ready_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_write_q  <= mem_write_d;
            mem_read_q   <= mem_read_d;
            cpu_reset_q  <= cpu_reset_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_read  = mem_read_q;
    assign cpu_reset     = cpu_reset_q;
    assign load_done     = load_done_q;
    assign load_error    = load_error_q;
    assign checksum      = checksum_q;

endmodule

// File: tb/tb_sap1_program_loader.sv
// Directed bench for the SAP-1 program loader with a 16x8 memory model
// (read latency 1) and hand-computed expected images, checksums and latencies.
module tb_sap1_program_loader;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       cpu_reset, load_done, load_error;
    logic [7:0] checksum;

    sap1_program_loader_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    sap1_program_loader #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .RD_LAT(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bus),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .load_error (load_error),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [16];
    logic       mem_clr = 1'b0;
    logic       corrupt = 1'b0;
    logic       acc_q;
    int         wr_cnt, orphan_cnt, overlap_cnt;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
            wr_cnt      <= 0;
            orphan_cnt  <= 0;
            overlap_cnt <= 0;
            acc_q       <= 1'b0;
        end else begin
            if (bus.mem_write) begin
                mem[bus.mem_addr] <= bus.mem_wdata;
                wr_cnt <= wr_cnt + 1;
                if (!acc_q) orphan_cnt <= orphan_cnt + 1;
            end
            if (bus.mem_read)
                bus.mem_rdata <= (corrupt && bus.mem_addr == 4'd5) ? 8'h00 : mem[bus.mem_addr];
            if (bus.mem_write && bus.mem_read) overlap_cnt <= overlap_cnt + 1;
            acc_q <= bus.in_valid && bus.in_ready;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        mem_clr = 1'b1;
        tick();
        mem_clr = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},   bus.in_ready, 1'b0);
        check({tag, "_mem_addr"},   bus.mem_addr, 4'h0);
        check({tag, "_mem_wdata"},  bus.mem_wdata, 8'h00);
        check({tag, "_mem_write"},  bus.mem_write, 1'b0);
        check({tag, "_mem_read"},   bus.mem_read, 1'b0);
        check({tag, "_cpu_reset"},  cpu_reset, 1'b1);
        check({tag, "_load_done"},  load_done, 1'b0);
        check({tag, "_load_error"}, load_error, 1'b0);
        check({tag, "_checksum"},   checksum, 8'h00);
    endtask

    task automatic check_image(input string tag, input logic [7:0] base, input logic [7:0] step);
        logic [7:0] exp_b;
        for (int i = 0; i < 16; i++) begin
            exp_b = base + step * 8'(i);
            check($sformatf("%s_mem%0d", tag, i), mem[i], exp_b);
        end
    endtask

    // Pulses start, then feeds image[i] = base + step*i until done/error or budget.
    task automatic run_load(input logic [7:0] base, input logic [7:0] step, input bit toggle,
                            input int start_at, output int cycles, output int accepts);
        int idx = 0;
        bit v, acc;
        start = 1'b1;
        tick();
        start = 1'b0;
        cycles = 1;
        check("start_cpu_reset", cpu_reset, 1'b1);
        check("start_load_done", load_done, 1'b0);
        check("start_in_ready", bus.in_ready, 1'b1);
        check("start_checksum", checksum, 8'h00);
        while (!(load_done || load_error) && cycles < 200) begin
            v = toggle ? ((cycles - 1) % 2 == 0) : 1'b1;
            v = v && (idx < 16);
            bus.in_valid = v;
            bus.in_data  = base + step * 8'(idx);
            start        = ((cycles - 1) == start_at);
            acc          = v && bus.in_ready;
            tick();
            cycles++;
            if (acc) begin
                idx++;
                if (idx == 16) check("ready_drop", bus.in_ready, 1'b0);
            end
        end
        start        = 1'b0;
        bus.in_valid = 1'b0;
        if (cycles >= 200) check("load_timeout", load_done | load_error, 1'b1);
        accepts = idx;
    endtask

    int cyc, accs;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        mem_clr      = 1'b1;
        tick();
        tick();
        mem_clr = 1'b0;
        tick();
        check_reset_outputs("rst");

        // IDLE ignores in_valid.
        reset = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        repeat (3) tick();
        check("idle_in_ready", bus.in_ready, 1'b0);
        check("idle_cpu_reset", cpu_reset, 1'b1);
        check("idle_writes", wr_cnt, 0);
        bus.in_valid = 1'b0;

        // Continuous source.
        run_load(8'h10, 8'h01, 1'b0, -1, cyc, accs);
        check("cont_latency", cyc, 50);
        check("cont_accepts", accs, 16);
        check("cont_done", load_done, 1'b1);
        check("cont_cpu_reset", cpu_reset, 1'b0);
        check("cont_error", load_error, 1'b0);
        check("cont_checksum", checksum, 8'h78);
        check("cont_writes", wr_cnt, 16);
        check_image("cont", 8'h10, 8'h01);
        repeat (3) tick();
        check("cont_done_held", load_done, 1'b1);

        // Toggling source.
        clear_mem();
        run_load(8'h10, 8'h01, 1'b1, -1, cyc, accs);
        check("tog_latency", cyc, 65);
        check("tog_done", load_done, 1'b1);
        check("tog_checksum", checksum, 8'h78);
        check("tog_writes", wr_cnt, 16);
        check("tog_orphan_writes", orphan_cnt, 0);
        check_image("tog", 8'h10, 8'h01);

        // Restart from DONE with all-0xFF image; checksum wraps.
        clear_mem();
        run_load(8'hFF, 8'h00, 1'b0, -1, cyc, accs);
        check("ff_latency", cyc, 50);
        check("ff_done", load_done, 1'b1);
        check("ff_cpu_reset", cpu_reset, 1'b0);
        check("ff_checksum", checksum, 8'hF0);
        check_image("ff", 8'hFF, 8'h00);

        // Corrupted readback at address 5.
        clear_mem();
        corrupt = 1'b1;
        run_load(8'h10, 8'h01, 1'b0, -1, cyc, accs);
        check("bad_latency", cyc, 50);
        check("bad_error", load_error, 1'b1);
        check("bad_done", load_done, 1'b0);
        check("bad_checksum", checksum, 8'h78);
        repeat (3) tick();
        check("bad_error_held", load_error, 1'b1);
        check("bad_cpu_reset_held", cpu_reset, 1'b1);
        corrupt = 1'b0;

        // Reset after the 7th accepted byte.
        clear_mem();
        start = 1'b1;
        tick();
        start = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.in_data = 8'hA0 + 8'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        reset = 1'b1;
        tick();
        check_reset_outputs("midrst");
        reset = 1'b0;
        bus.in_valid = 1'b1;
        repeat (4) tick();
        check("midrst_idle_ready", bus.in_ready, 1'b0);
        bus.in_valid = 1'b0;
        check("midrst_writes", wr_cnt, 7);
        for (int i = 0; i < 7; i++)
            check($sformatf("midrst_mem%0d", i), mem[i], 8'hA0 + 8'(i));
        check("midrst_mem7", mem[7], 8'h00);

        // Reload from address 0 with a stray start pulse mid-load.
        run_load(8'h10, 8'h01, 1'b0, 5, cyc, accs);
        check("reload_latency", cyc, 50);
        check("reload_done", load_done, 1'b1);
        check("reload_checksum", checksum, 8'h78);
        check("reload_writes", wr_cnt, 23);
        check_image("reload", 8'h10, 8'h01);
        check("rw_overlap", overlap_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
